fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 93 +++++++++
 tb/tb_fifo_stream_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Pulls words from a registered-output FIFO into a 2-entry buffer and presents them as a valid/ready stream.
// Read-to-valid latency is 2 cycles; reads stop when the buffer plus the in-flight read would exceed 2 words.
module fifo_stream_reader #(
  parameter int width   = 8,
  parameter int pkt_len = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_full_i,
  input  logic             fifo_wr_en_i,
  input  logic [width-1:0] fifo_dout_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [width-1:0] m_data_o,
  output logic             m_last_o,
  output logic [15:0]      beats_o
);

  localparam logic [7:0] last_idx = 8'(pkt_len - 1);

  logic [1:0]       count_q;
  logic             pending_q;
  logic             run_q;
  logic [width-1:0] head_q;
  logic [width-1:0] tail_q;
  logic [7:0]       idx_q;
  logic [15:0]      beats_q;
  logic             pop;
  logic             capture;
  logic [2:0]       occ;

  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = head_q;
  assign m_last_o  = m_valid_o && (idx_q == last_idx);
  assign beats_o   = beats_q;

  // A flush cycle neither pops nor captures.
  assign pop     = m_valid_o && m_ready_i && !flush_i;
  assign capture = pending_q && !flush_i;
  assign occ     = {1'b0, count_q} + {2'b00, pending_q};

  // run_q holds off the first read until one edge after reset release; a full FIFO
  // ignores a read that coincides with a write, so that case is suppressed.
  assign fifo_rd_en_o = run_q && enable_i && !flush_i && !fifo_empty_i
                        && !(fifo_full_i && fifo_wr_en_i)
                        && (occ < (3'd2 + {2'b00, m_valid_o && m_ready_i}));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      run_q     <= 1'b0;
      pending_q <= 1'b0;
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      idx_q     <= 8'd0;
      beats_q   <= 16'd0;
    end else begin
      run_q     <= 1'b1;
      pending_q <= fifo_rd_en_o;
      if (flush_i) begin
        count_q <= 2'd0;
        idx_q   <= 8'd0;
      end else begin
        count_q <= count_q - {1'b0, pop} + {1'b0, capture};
        if (pop) begin
          idx_q   <= (idx_q == last_idx) ? 8'd0 : idx_q + 8'd1;
          beats_q <= beats_q + 16'd1;
        end
        case ({pop, capture})
          2'b10: head_q <= tail_q;
          2'b01: begin
            if (count_q == 2'd0) head_q <= fifo_dout_i;
            else                 tail_q <= fifo_dout_i;
          end
          2'b11: begin
            if (count_q == 2'd2) begin
              head_q <= tail_q;
              tail_q <= fifo_dout_i;
            end else begin
              head_q <= fifo_dout_i;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and stream scoreboard, directed vectors and random traffic.
module tb_fifo_stream_reader;
  localparam int W   = 8;
  localparam int PKT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, enable, flush, fifo_empty, fifo_full, fifo_wr_en, m_ready;
  logic [W-1:0] fifo_dout;
  logic         rd_en, m_valid, m_last;
  logic [W-1:0] m_data;
  logic [15:0]  beats;

  fifo_stream_reader #(.width(W), .pkt_len(PKT)) dut (
    .clk_i(clk), .reset_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full), .fifo_wr_en_i(fifo_wr_en),
    .fifo_dout_i(fifo_dout), .fifo_rd_en_o(rd_en), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last), .beats_o(beats)
  );

  typedef struct {
    logic         rdy;
    logic         en;
    logic         e_rd;
    logic         e_vld;
    logic [W-1:0] e_dat;
    logic         e_last;
  } vec_t;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] fq[$];        // words sitting in the FIFO
  logic [W-1:0] rd_q[$];      // words read from the FIFO, not yet delivered
  int           rd_stamp[$];  // cycle in which each of those words was read
  int           cyc = 0;
  int           rel = 0;
  int           mdl_idx = 0;
  logic [15:0]  mdl_beats = 16'd0;
  logic         e_pop = 1'b0;
  logic         s_rd, s_vld, s_last;
  logic [W-1:0] s_data;
  logic [15:0]  s_beats;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Mid-cycle sample and comparison against the reference model.
  task automatic tick();
    int   occ;
    logic e_vld, e_rd;
    @(negedge clk);
    s_rd = rd_en; s_vld = m_valid; s_data = m_data; s_last = m_last; s_beats = beats;
    if (!rst_n) begin
      e_pop = 1'b0;
      chk("rst_rd", s_rd, 0);
      chk("rst_vld", s_vld, 0);
      chk("rst_data", s_data, 0);
      chk("rst_last", s_last, 0);
      chk("rst_beats", s_beats, 0);
    end else begin
      e_vld = (rd_q.size() > 0) && (rd_stamp[0] <= cyc - 2);
      e_pop = e_vld && m_ready && !flush;
      occ   = rd_q.size() - ((e_vld && m_ready) ? 1 : 0);
      e_rd  = (rel > 0) && enable && !flush && !fifo_empty
              && !(fifo_full && fifo_wr_en) && (occ < 2);
      chk("sb_vld", s_vld, e_vld);
      chk("sb_rd", s_rd, e_rd);
      chk("sb_beats", s_beats, mdl_beats);
      if (e_vld && s_vld) begin
        chk("sb_data", s_data, rd_q[0]);
        chk("sb_last", s_last, (mdl_idx == PKT - 1));
      end
    end
  endtask

  // Clock edge: advance the FIFO and scoreboard, then present new FIFO output.
  task automatic edge_step();
    logic [W-1:0] nd;
    nd = fifo_dout;
    @(posedge clk);
    if (!rst_n) begin
      rd_q.delete(); rd_stamp.delete();
      mdl_beats = 16'd0; mdl_idx = 0; rel = 0;
    end else begin
      if (flush) begin
        rd_q.delete(); rd_stamp.delete();
        mdl_idx = 0;
      end else if (e_pop) begin
        void'(rd_q.pop_front());
        void'(rd_stamp.pop_front());
        mdl_beats = mdl_beats + 16'd1;
        mdl_idx   = (mdl_idx + 1) % PKT;
      end
      if (s_rd && !(fifo_full && fifo_wr_en) && fq.size() > 0) begin
        nd = fq.pop_front();
        rd_q.push_back(nd);
        rd_stamp.push_back(cyc);
      end
      rel++;
    end
    cyc++;
    #1;
    fifo_dout  = nd;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic cycle();
    tick();
    edge_step();
  endtask

  initial begin
    vec_t         tbl[6];
    int           nbeat, firstv, lastv, reads, lastmask;
    logic [15:0]  b0;
    logic [W-1:0] got[$];

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; fifo_full = 1'b0; fifo_wr_en = 1'b0;
    m_ready = 1'b0; fifo_dout = '0; fifo_empty = 1'b1;
    cycle();
    rst_n = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    cycle(); cycle();

    // Three preloaded words, sink always ready.
    for (int i = 0; i < 6; i++) begin
      m_ready = tbl[i].rdy; enable = tbl[i].en;
      tick();
      chk("v038_rd", s_rd, tbl[i].e_rd);
      chk("v038_vld", s_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk("v038_data", s_data, tbl[i].e_dat);
        chk("v038_last", s_last, tbl[i].e_last);
      end
      edge_step();
    end
    chk("v038_beats", beats, 3);

    // Eight-word burst: two packets back to back.
    enable = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    enable = 1'b1; m_ready = 1'b1;
    nbeat = 0; firstv = -1; lastv = -1; lastmask = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_vld) begin
        nbeat++;
        if (firstv < 0) firstv = i;
        lastv = i;
        if (s_last) lastmask = lastmask | (1 << nbeat);
      end
      edge_step();
    end
    chk("burst_beats", nbeat, 8);
    chk("burst_first", firstv, 2);
    chk("burst_span", lastv - firstv + 1, 8);
    chk("burst_lastpos", lastmask, (1 << 4) | (1 << 8));

    // Sink stalled: only two reads, head frozen, then ordered drain.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'hB1 + 8'(i));
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_rd) reads++;
      if (i >= 2) chk("stall_head", s_data, 8'hB1);
      edge_step();
    end
    chk("stall_reads", reads, 2);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_vld) got.push_back(s_data);
      edge_step();
    end
    chk("stall_count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++) chk("stall_order", got[i], 8'hB1 + 8'(i));

    // Full FIFO being written ignores reads.
    for (int i = 0; i < 3; i++) push_word(8'hC1 + 8'(i));
    fifo_full = 1'b1; fifo_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fullwr_rd", s_rd, 0);
      edge_step();
    end
    fifo_wr_en = 1'b0;
    tick();
    chk("fullwr_resume", s_rd, 1);
    edge_step();
    fifo_full = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // Flush with a buffered word and a read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hD1 + 8'(i));
    cycle(); cycle();
    b0 = beats;
    flush = 1'b1; m_ready = 1'b1;
    tick();
    chk("flush_rd", s_rd, 0);
    edge_step();
    flush = 1'b0; enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("flush_vld", s_vld, 0);
      chk("flush_beats", s_beats, b0);
      edge_step();
    end
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) push_word(8'hE1 + 8'(i));
    for (int i = 0; i < 3; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", rd_en, 0);
    chk("arst_vld", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_last", m_last, 0);
    chk("arst_beats", beats, 0);
    cycle();
    rst_n = 1'b1; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_nostale", s_vld, 0);
      edge_step();
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      m_ready    = ($urandom_range(0, 3) != 0);
      enable     = ($urandom_range(0, 7) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      fifo_full  = ($urandom_range(0, 9) == 0);
      fifo_wr_en = ($urandom_range(0, 1) == 1);
      if (fq.size() < 12 && $urandom_range(0, 1) == 1) push_word(8'($urandom));
      cycle();
    end
    flush = 1'b0; fifo_full = 1'b0; fifo_wr_en = 1'b0; enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("drain_fifo", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
